md_issue_ctrl: RTL



---
 rtl/md_pkg.sv | 30 +++
 rtl/md_issue_ctrl_if.sv | 25 ++
 rtl/md_wdog.sv | 38 +++
 rtl/md_issue_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and default latencies for the HI/LO multiply/divide issue controller.
package md_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned DEF_LAT_MUL     = 5;
  localparam int unsigned DEF_LAT_DIV     = 10;
  localparam int unsigned DEF_WDOG_MARGIN = 2;
  localparam int unsigned CNT_W           = 8;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_BUSY   = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Strobe/operand/status bus between the issue controller (master) and the muldiv unit (slave).
interface md_issue_ctrl_if;
  import md_pkg::*;

  logic            md_loen;
  logic            md_hien;
  logic            md_mdsel;
  logic            md_unsigned;
  logic            md_add;
  logic [XLEN-1:0] md_op1;
  logic [XLEN-1:0] md_op2;
  logic            md_busy;
  logic [XLEN-1:0] md_hi;
  logic [XLEN-1:0] md_lo;

  modport master (
    output md_loen, md_hien, md_mdsel, md_unsigned, md_add, md_op1, md_op2,
    input  md_busy, md_hi, md_lo
  );

  modport slave (
    input  md_loen, md_hien, md_mdsel, md_unsigned, md_add, md_op1, md_op2,
    output md_busy, md_hi, md_lo
  );
endinterface

// File: rtl/md_wdog.sv
// Sticky latency watchdog: counts down from the expected latency plus margin after each start.
module md_wdog
  import md_pkg::*;
#(
  parameter int unsigned LAT_MUL     = DEF_LAT_MUL,
  parameter int unsigned LAT_DIV     = DEF_LAT_DIV,
  parameter int unsigned WDOG_MARGIN = DEF_WDOG_MARGIN
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic active,
  input  logic in_busy,
  input  logic md_busy,
  output logic wdog_err
);

  logic [CNT_W-1:0] exp_cnt;

  // The trip registers on the edge where exp_cnt reaches zero, so wdog_err is visible that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_cnt  <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (start) begin
        exp_cnt <= is_div ? CNT_W'(LAT_DIV + WDOG_MARGIN) : CNT_W'(LAT_MUL + WDOG_MARGIN);
      end else if (active && (exp_cnt != '0)) begin
        exp_cnt <= exp_cnt - CNT_W'(1);
      end
      if (!start && in_busy && md_busy && (exp_cnt <= CNT_W'(1))) begin
        wdog_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the HI/LO muldiv unit: decode, stall, HI/LO read-back, watchdog.
// Define MD_MADD_EN to decode MADD/MADDU; otherwise they behave as OP_NONE and md_add stays 0.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned LAT_MUL     = DEF_LAT_MUL,
  parameter int unsigned LAT_DIV     = DEF_LAT_DIV,
  parameter int unsigned WDOG_MARGIN = DEF_WDOG_MARGIN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  md_op_t          op_code,
  input  logic            ex_flush,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            stall,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_data,
  output logic            div_zero,
  output logic            wdog_err,
  md_issue_ctrl_if.master md
);

  md_state_t state;
  md_op_t    op_eff;
  logic      hilo_op;
  logic      blocked;
  logic      accept;
  logic      start;
  logic      is_div;

  // Legal-op filter; disabled accumulate ops collapse to OP_NONE.
  always_comb begin
    op_eff = OP_NONE;
    case (op_code)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: op_eff = op_code;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU:                  op_eff = op_code;
`endif
      default:                            op_eff = OP_NONE;
    endcase
  end

  assign hilo_op = op_valid & ~ex_flush & (op_eff != OP_NONE);
  assign blocked = (state == ST_ISSUED) | md.md_busy;
  assign stall   = hilo_op & blocked;
  assign accept  = hilo_op & ~blocked;
  assign is_div  = (op_eff == OP_DIV) | (op_eff == OP_DIVU);
  assign start   = accept & ((op_eff == OP_MULT) | (op_eff == OP_MULTU) | is_div |
                             (op_eff == OP_MADD) | (op_eff == OP_MADDU));

  // A start in BUSY (md_busy already low) goes straight back to ISSUED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (start) begin
      state <= ST_ISSUED;
    end else begin
      case (state)
        ST_ISSUED: state <= ST_BUSY;
        ST_BUSY:   state <= md.md_busy ? ST_BUSY : ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Unit strobes and read-back are only driven for the accepted instruction.
  always_comb begin
    md.md_loen     = 1'b0;
    md.md_hien     = 1'b0;
    md.md_mdsel    = 1'b0;
    md.md_unsigned = 1'b0;
    md.md_add      = 1'b0;
    md.md_op1      = '0;
    md.md_op2      = '0;
    rd_valid       = 1'b0;
    rd_data        = '0;
    div_zero       = 1'b0;
    if (start) begin
      md.md_loen     = 1'b1;
      md.md_hien     = 1'b1;
      md.md_mdsel    = is_div;
      md.md_unsigned = (op_eff == OP_MULTU) | (op_eff == OP_DIVU) | (op_eff == OP_MADDU);
`ifdef MD_MADD_EN
      md.md_add      = (op_eff == OP_MADD) | (op_eff == OP_MADDU);
`else
      md.md_add      = 1'b0;
`endif
      md.md_op1      = rs_val;
      md.md_op2      = rt_val;
      div_zero       = is_div & (rt_val == '0);
    end else if (accept) begin
      case (op_eff)
        OP_MTLO: begin
          md.md_loen = 1'b1;
          md.md_op1  = rs_val;
        end
        OP_MTHI: begin
          md.md_hien = 1'b1;
          md.md_op1  = rs_val;
        end
        OP_MFHI: begin
          rd_valid = 1'b1;
          rd_data  = md.md_hi;
        end
        OP_MFLO: begin
          rd_valid = 1'b1;
          rd_data  = md.md_lo;
        end
        default: ;
      endcase
    end
  end

  md_wdog #(
    .LAT_MUL     (LAT_MUL),
    .LAT_DIV     (LAT_DIV),
    .WDOG_MARGIN (WDOG_MARGIN)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_div   (is_div),
    .active   (state != ST_IDLE),
    .in_busy  (state == ST_BUSY),
    .md_busy  (md.md_busy),
    .wdog_err (wdog_err)
  );

endmodule
